// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - decode-stage register file with pending-write scoreboard and W->D bypass
module grf_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int CNT_W  = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   input  logic [NUM_RD-1:0]        use_rd,
   output logic [NUM_RD*DATA_W-1:0] rd,
   output logic [NUM_RD-1:0]        busy,
   output logic                     stall,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_a3,
   output logic                     iss_ready,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wa,
   input  logic [DATA_W-1:0]        wd,
   input  logic                     flush,
   output logic                     err
);

   localparam int              NREG    = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] mem_q [NREG];
   logic [DATA_W-1:0] mem_d [NREG];
   logic [CNT_W-1:0]  cnt_q [NREG];
   logic [CNT_W-1:0]  cnt_d [NREG];
   logic              err_q, err_d;

   logic [ADDR_W-1:0] ra_a [NUM_RD];
   logic [CNT_W-1:0]  eff  [NUM_RD];
   logic              inc, dec;

   // A retire to reg 0 is a no-op for both data and scoreboard
   assign dec = we && (wa != '0);

   // A saturated destination holds decode, unless the same register retires this cycle
   assign iss_ready = !((iss_a3 != '0) && (cnt_q[iss_a3] == CNT_MAX) && !(dec && (wa == iss_a3)));

   // Stalled instructions never count themselves as in flight
   assign inc   = iss_valid && iss_ready && !stall && (iss_a3 != '0);
   assign stall = |busy;
   assign err   = err_q;

   // Split the packed address bus into per-port addresses
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         ra_a[i] = ra[i*ADDR_W +: ADDR_W];
      end
   end

   // Read ports: zero for reg 0, WB bypass, else array; busy ignores a same-cycle retire
   always_comb begin
      rd   = '0;
      busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (ra_a[i] == '0) begin
            rd[i*DATA_W +: DATA_W] = '0;
         end else if (we && (wa == ra_a[i])) begin
            rd[i*DATA_W +: DATA_W] = wd;
         end else begin
            rd[i*DATA_W +: DATA_W] = mem_q[ra_a[i]];
         end
         eff[i]  = cnt_q[ra_a[i]] - CNT_W'(dec && (wa == ra_a[i]));
         busy[i] = use_rd[i] && (ra_a[i] != '0) && (eff[i] != '0);
      end
   end

   // Next state: WB write, per-register counter update, sticky underflow flag
   always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (dec) begin
         mem_d[wa] = wd;
      end
      if (dec && (cnt_q[wa] == '0) && !(inc && (iss_a3 == wa))) begin
         err_d = 1'b1;
      end
      for (int r = 1; r < NREG; r++) begin
         if (flush) begin
            cnt_d[r] = '0;
         end else if (inc && (iss_a3 == ADDR_W'(r)) && !(dec && (wa == ADDR_W'(r)))) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (dec && (wa == ADDR_W'(r)) && !(inc && (iss_a3 == ADDR_W'(r)))
                      && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
         end
      end
   end

   // State registers; reset clears everything without waiting for a clock
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) begin
            mem_q[r] <= '0;
            cnt_q[r] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         mem_q <= mem_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule
